// File: rtl/hs_elastic_buffer_pkg.sv
// Shared definitions for the handshake elastic buffer: handshake constants,
// counter types and the pointer-width helper.
package hs_elastic_buffer_pkg;

    localparam int HS_ACK_PULSE = 1;
    localparam int CNT_W        = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t words_in;
        cnt_t words_out;
    } hs_counts_t;

    // Address bits needed for 'value' entries, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_buffer_mem.sv
// Storage array for the elastic buffer: synchronous write port and
// combinational read port.
module hs_buffer_mem
    import hs_elastic_buffer_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth      = 4,
    localparam int addr_w    = clog2(depth)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_w-1:0]     wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [addr_w-1:0]     rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem_q [depth];

    // NOTE: storage has no reset; the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/hs_elastic_buffer.sv
// Elastic FIFO stage between a req/ack producer and a req/ack consumer, with
// occupancy and transfer counters for throughput measurement.
module hs_elastic_buffer
    import hs_elastic_buffer_pkg::*;
#(
    parameter int                   data_width    = 32,
    parameter int                   depth         = 4,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  up_req,
    input  logic                  up_ack,
    input  logic [data_width-1:0] up_din,
    input  logic                  dn_req,
    output logic                  dn_ack,
    output logic [data_width-1:0] dout,
    output logic [CNT_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      count_in,
    output logic [CNT_W-1:0]      count_out,
    output logic                  overflow
);

    localparam int              PtrW    = clog2(depth);
    localparam cnt_t            DepthC  = CNT_W'(depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(depth - 1);

    if (depth < 2 || HS_ACK_PULSE != 1) begin : g_param_check
        $error("hs_elastic_buffer: depth must be >= 2 with a single-cycle ack");
    end

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    cnt_t                  occ_q, occ_d;
    hs_counts_t            counts_q, counts_d;
    logic                  ovf_q, ovf_d;
    logic                  up_req_q, up_req_d;
    logic                  dn_ack_q, dn_ack_d;
    logic [data_width-1:0] dout_q, dout_d;

    logic                  full;
    logic                  wr_en;
    logic                  pop;
    logic [data_width-1:0] rd_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Pop only from stored words and never on the cycle after an ack,
    // so a word written at one edge is delivered at the next edge at the earliest.
    assign full  = (occ_q == DepthC);
    assign wr_en = up_ack & ~full;
    assign pop   = dn_req & ~dn_ack_q & (occ_q != '0);

    hs_buffer_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (up_din),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // NOTE: every next-state value gets its default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        counts_d = counts_q;
        ovf_d    = ovf_q;
        dn_ack_d = 1'b0;
        dout_d   = dout_q;

        if (wr_en) begin
            wr_ptr_d          = ptr_inc(wr_ptr_q);
            counts_d.words_in = counts_q.words_in + CNT_W'(1);
        end
        if (up_ack && full) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d           = ptr_inc(rd_ptr_q);
            dn_ack_d           = 1'b1;
            dout_d             = rd_data;
            counts_d.words_out = counts_q.words_out + CNT_W'(1);
        end

        occ_d    = occ_q + CNT_W'(wr_en) - CNT_W'(pop);
        // Upstream has at most one ack in flight, so free space now covers it.
        up_req_d = (occ_d < DepthC);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            counts_q <= '0;
            ovf_q    <= 1'b0;
            up_req_q <= 1'b0;
            dn_ack_q <= 1'b0;
            dout_q   <= initial_value;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            counts_q <= counts_d;
            ovf_q    <= ovf_d;
            up_req_q <= up_req_d;
            dn_ack_q <= dn_ack_d;
            dout_q   <= dout_d;
        end
    end

    assign up_req    = up_req_q;
    assign dn_ack    = dn_ack_q;
    assign dout      = dout_q;
    assign occupancy = occ_q;
    assign count_in  = counts_q.words_in;
    assign count_out = counts_q.words_out;
    assign overflow  = ovf_q;

endmodule

// File: doc/hs_elastic_buffer.md
Name: hs_elastic_buffer

Overview:
- Elastic FIFO stage that sits directly downstream of an arf `out_N` port, or directly upstream of an arf `in_N` port.
- It absorbs stalls between the dataflow graph and the consumer, or between the producer and the graph.
- Toward its upstream side it behaves as a consumer: it drives req and samples ack and data.
- Toward its downstream side it behaves as a producer: it samples req and drives a one-cycle ack with data.
- It exposes occupancy and transfer counters for throughput measurement in benches.

Parameters:
- data_width, 32, width of each data word.
- depth, 4, number of storage entries. Must be ≥2; need not be a power of two.
- initial_value, 0, value driven on dout at reset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- up_req  output  1  request to the upstream producer or arf output.
- up_ack  input  1  one-cycle acknowledge from upstream; up_din is valid in the same cycle.
- up_din  input  data_width  upstream data.
- dn_req  input  1  request from the downstream consumer or arf input.
- dn_ack  output  1  one-cycle acknowledge to downstream.
- dout  output  data_width  data word; valid while dn_ack=1 and held until the next ack.
- occupancy  output  32  number of stored words.
- count_in  output  32  total words accepted since reset.
- count_out  output  32  total words delivered since reset.
- overflow  output  1  sticky error: up_ack was received while full.

Behaviour:
- Reset (async, while rst=1):
  - up_req=0, dn_ack=0, dout=initial_value.
  - occupancy=0, count_in=0, count_out=0, overflow=0.
  - Read/write pointers=0; stored contents are discarded.
  - up_ack and dn_req are ignored while rst=1.
- Definitions, evaluated at each posedge when not in reset:
  - push = up_ack.
  - pop = dn_req & ~dn_ack & (occupancy>0).
  - occ_next = occupancy + push − pop. Simultaneous push and pop leave occupancy unchanged.
- Push:
  - If occupancy<depth: write up_din at wr_ptr; wr_ptr wraps depth−1→0; count_in+1.
  - If occupancy==depth: the word is dropped, overflow<=1, occupancy is unchanged.
  - overflow is unreachable with compliant peers and exists only to catch protocol errors.
- Pop:
  - dn_ack<=1 and dout<=mem[rd_ptr]; rd_ptr wraps; count_out+1.
  - Otherwise dn_ack<=0 and dout holds its value.
  - dn_ack is never high on two consecutive cycles.
- Pop with occupancy==0 while push is asserted in the same cycle: no pop. No bypass is allowed.
  - Minimum latency from up_ack sampled to dn_ack high is 2 edges: write at edge e, ack at e+1.
- up_req <= (occ_next < depth), registered.
  - Upstream acks only on req & ~ack, so at most one ack is ever in flight and pushes occur at most every other edge.
  - This rule therefore guarantees room for an in-flight ack.
- Steady-state throughput equals the upstream rate: one word every 2 cycles with zero-fail peers.
- Counters are 32-bit and wrap modulo 2^32.
- Mid-operation reset: the state clears immediately (async). An up_ack that arrives on the first edge after deassertion is accepted normally, which tolerates an upstream that was not reset.

Decomposition:
- Shared package holds:
  - handshake constants: HS_ACK_PULSE=1 cycle, counter width 32;
  - a function clog2 for pointer width, minimum 1 bit.
- One sub-module, hs_buffer_mem: depth×data_width register array with wr_en, wr_addr, wr_data and a combinational rd_addr→rd_data. No reset on the storage.
- Pointers, occupancy, handshake and counters stay in hs_elastic_buffer.

Test Plan:
1. Reset then idle downstream (dn_req=0), upstream producer supplying 0,1,2,…:
   - occupancy climbs to 4 and up_req falls;
   - count_in=4, overflow=0, dn_ack never asserted.
2. Continue from scenario 1 and raise dn_req permanently:
   - downstream receives 0,1,2,3,4,… in order with no gaps or duplicates;
   - dn_ack pulses are never back-to-back;
   - after 5000 delivered words, count_out=5000 and count_in−count_out=occupancy.
3. Empty buffer, single up_ack with up_din=0xA5 at edge e, dn_req held high:
   - dn_ack=1 with dout=0xA5 exactly after edge e+1;
   - occupancy back to 0 after edge e+1.
4. Wrap-around with depth=3 (non-power-of-two), 10 words 10..19 streamed with random dn_req gaps:
   - output order is exactly 10..19; occupancy never exceeds 3.
5. Forced protocol violation: buffer full (occupancy=4), inject up_ack with 0xFF:
   - overflow=1 and stays set; occupancy stays 4; 0xFF is never output.
6. Assert rst asynchronously mid-stream (between edges, occupancy=2, dn_ack=1):
   - all outputs read reset values immediately (dn_ack=0, dout=initial_value, counters=0);
   - after release, up_req=1 on the first edge and streaming resumes cleanly.
